// File: rtl/fifo_drain_pkg.sv
// Shared types for the FIFO drain port: buffer-occupancy state encoding and
// performance-counter width.
package fifo_drain_pkg;

    localparam int unsigned PERF_CNT_W = 32;

    // Encoding doubles as the buffered-entry count (level_o).
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } drain_state_e;

endpackage

// File: rtl/drain_sat_counter.sv
// Saturating event counter used for drain-port stall/starve statistics.
// Only built when FIFO_DRAIN_PERF_EN is defined.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset (clears count)
//   inc_i       - count one event this cycle
//   cnt_o       - current count, sticks at all-ones
`ifdef FIFO_DRAIN_PERF_EN
module drain_sat_counter
    import fifo_drain_pkg::*;
#(
    parameter int unsigned W = PERF_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Increment unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/fifo_drain_port.sv
// Read-side drain port for the synchronous FIFO. Pops the FIFO head into a
// two-entry buffer (output register + skid register) and presents a
// registered valid/ready stream. The pop never depends on out_ready_i.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   flush_i        - discard buffered entries (same cycle as FIFO flush)
//   fifo_empty_i   - FIFO empty flag
//   fifo_data_i    - FIFO head data
//   fifo_pop_o     - pop FIFO head this cycle (combinational)
//   out_valid_o    - out_data_o holds a valid entry
//   out_data_o     - output payload (registered)
//   out_ready_i    - consumer accepts this cycle
//   level_o        - entries buffered, 0..2
//   stall_cnt_o    - (FIFO_DRAIN_PERF_EN) cycles valid & ~ready, saturating
//   starve_cnt_o   - (FIFO_DRAIN_PERF_EN) cycles empty buffer & empty FIFO
module fifo_drain_port
    import fifo_drain_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter type         dtype      = logic [DATA_WIDTH-1:0]
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush_i,
    input  logic       fifo_empty_i,
    input  dtype       fifo_data_i,
    output logic       fifo_pop_o,
    output logic       out_valid_o,
    output dtype       out_data_o,
    input  logic       out_ready_i,
    output logic [1:0] level_o
`ifdef FIFO_DRAIN_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt_o,
    output logic [PERF_CNT_W-1:0] starve_cnt_o
`endif
);

    drain_state_e state_q;
    drain_state_e state_d;
    dtype         out_q;
    dtype         out_d;
    dtype         skid_q;
    dtype         skid_d;
    logic         fire;

    // Pop only from registered state and FIFO/flush/reset; room exists unless full.
    assign fifo_pop_o = rst_n & ~flush_i & ~fifo_empty_i & (state_q != S_TWO);
    assign fire       = (state_q != S_EMPTY) & out_ready_i;

    // Next-state and datapath load selection.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        unique case (state_q)
            S_EMPTY: begin
                if (fifo_pop_o) begin
                    state_d = S_ONE;
                    out_d   = fifo_data_i;
                end
            end
            S_ONE: begin
                if (fire && fifo_pop_o) begin
                    out_d = fifo_data_i;
                end else if (fire) begin
                    state_d = S_EMPTY;
                end else if (fifo_pop_o) begin
                    state_d = S_TWO;
                    skid_d  = fifo_data_i;
                end
            end
            S_TWO: begin
                if (fire) begin
                    state_d = S_ONE;
                    out_d   = skid_q;
                end
            end
            default: begin
                state_d = S_EMPTY;
            end
        endcase
        // Flush drops everything buffered; a fire this cycle has already completed.
        if (flush_i) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign out_valid_o = (state_q != S_EMPTY);
    assign out_data_o  = out_q;
    assign level_o     = 2'(state_q);

`ifdef FIFO_DRAIN_PERF_EN
    logic stall_inc_c;
    logic starve_inc_c;

    assign stall_inc_c  = out_valid_o & ~out_ready_i;
    assign starve_inc_c = (state_q == S_EMPTY) & fifo_empty_i;

    drain_sat_counter #(.W(PERF_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (stall_inc_c),
        .cnt_o (stall_cnt_o)
    );

    drain_sat_counter #(.W(PERF_CNT_W)) u_starve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (starve_inc_c),
        .cnt_o (starve_cnt_o)
    );
`endif

endmodule
